// File: rtl/out_port_pkg.sv
// Shared constants and types for the CPU output-port reader.
// Defaults used by out_port_fifo and out_port_reader (see OUT_PORT_DEDUP_EN in the top).
package out_port_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    // Pointer width for a power-of-two depth; never below one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PTR_W = ptr_w(DEPTH_DEF);

    typedef logic [PTR_W:0] count_t;

endpackage

// File: rtl/out_port_fifo.sv
// Generic show-ahead FIFO: head entry is presented on dout while not empty.
// A push on a full FIFO is ignored unless a pop happens in the same cycle.
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    logic do_push;
    logic do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_FULL);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/out_port_reader.sv
// Captures CPU output-port writes into a FIFO and serves them over valid/ready.
// Define OUT_PORT_DEDUP_EN to discard writes repeating the last accepted value.
module out_port_reader
    import out_port_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     out_we,
    input  logic [DATA_W-1:0]        out_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    logic pop;
    logic is_dup;
    logic candidate;
    logic push;
    logic drop;

    logic overflow_reg;
    logic overflow_next;

    assign pop       = !fifo_empty && rd_ready;
    assign candidate = out_we && !is_dup;
    assign push      = candidate && (!fifo_full || pop);
    assign drop      = candidate && fifo_full && !pop;

`ifdef OUT_PORT_DEDUP_EN
    logic [DATA_W-1:0] last_reg;
    logic              last_valid_reg;

    assign is_dup = last_valid_reg && (out_data == last_reg);

    // Only values that actually enter the FIFO become the comparison reference.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg       <= '0;
            last_valid_reg <= 1'b0;
        end else if (push) begin
            last_reg       <= out_data;
            last_valid_reg <= 1'b1;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    always_comb begin
        overflow_next = overflow_reg;
        if (clr_overflow) begin
            overflow_next = 1'b0;
        end
        if (drop) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= overflow_next;
        end
    end

    out_port_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    (out_data),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (count)
    );

    assign rd_valid = !fifo_empty;
    assign overflow = overflow_reg;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
            assign rd_data[gi] = fifo_dout[gi] & rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_out_port_reader.sv
// Self-checking bench for out_port_reader: vector table, directed corner cases,
// and random traffic against a queue-based reference model (honours OUT_PORT_DEDUP_EN).
module tb_out_port_reader;
    import out_port_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          out_we;
    logic [DW-1:0] out_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    count_t        count;
    logic          overflow;
    logic          clr_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovf;
    logic [DW-1:0] m_last;
    logic          m_last_ok;

    out_port_reader #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .out_we       (out_we),
        .out_data     (out_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [DW-1:0] data;
        logic          rdy;
        logic          clr;
        logic          e_valid;
        logic [DW-1:0] e_data;
        int            e_count;
        logic          e_ovf;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: FIFO as a queue; one call represents one clock edge.
    task automatic model_edge(input logic we, input logic [DW-1:0] data,
                              input logic rdy, input logic clr);
        bit do_pop;
        bit dup;
        bit dropped;
        do_pop  = (mq.size() > 0) && rdy;
        dup     = 1'b0;
        dropped = 1'b0;
`ifdef OUT_PORT_DEDUP_EN
        dup = m_last_ok && (data == m_last);
`endif
        if (do_pop) void'(mq.pop_front());
        if (we && !dup) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(data);
                m_last    = data;
                m_last_ok = 1'b1;
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf     = 1'b0;
        m_last    = '0;
        m_last_ok = 1'b0;
    endtask

    task automatic model_check(input string name);
        int exp_data;
        exp_data = (mq.size() > 0) ? int'(mq[0]) : 0;
        chk({name, " rd_valid"}, int'(rd_valid), (mq.size() > 0) ? 1 : 0);
        chk({name, " rd_data"},  int'(rd_data),  exp_data);
        chk({name, " count"},    int'(count),    mq.size());
        chk({name, " overflow"}, int'(overflow), int'(m_ovf));
    endtask

    task automatic step(input logic we, input logic [DW-1:0] data,
                        input logic rdy, input logic clr, input string name);
        out_we       = we;
        out_data     = data;
        rd_ready     = rdy;
        clr_overflow = clr;
        @(posedge clk);
        #1;
        model_edge(we, data, rdy, clr);
        model_check(name);
    endtask

    task automatic do_reset();
        out_we = 1'b0; out_data = '0; rd_ready = 1'b0; clr_overflow = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        model_check("reset");
    endtask

    initial begin
        logic [DW-1:0] exp_rd[$];
        int exp_cnt;

        // --- basic push/pop vector table ---
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'h11, 1, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 2, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 3, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 2, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 1, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tbl[7] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 1, 1'b0};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            out_we = tbl[i].we; out_data = tbl[i].data;
            rd_ready = tbl[i].rdy; clr_overflow = tbl[i].clr;
            @(posedge clk);
            #1;
            model_edge(tbl[i].we, tbl[i].data, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d rd_valid", i), int'(rd_valid), int'(tbl[i].e_valid));
            chk($sformatf("tbl%0d rd_data", i),  int'(rd_data),  int'(tbl[i].e_data));
            chk($sformatf("tbl%0d count", i),    int'(count),    tbl[i].e_count);
            chk($sformatf("tbl%0d overflow", i), int'(overflow), int'(tbl[i].e_ovf));
        end

        // --- overflow: 10 pushes into DEPTH=8 ---
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "fill10");
        chk("fill10 count8", int'(count), 8);
        chk("fill10 overflow", int'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain10 head%0d", i), int'(rd_data), i);
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain10");
        end
        chk("drain10 empty valid", int'(rd_valid), 0);
        chk("drain10 empty data", int'(rd_data), 0);

        // --- full with simultaneous push/pop, 3 wrap passes ---
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) step(1'b1, DW'(p * 16 + i), 1'b0, 1'b0, "pass fill");
            step(1'b1, DW'(8'hA0 + p), 1'b1, 1'b0, "pass pushpop");
            chk($sformatf("pass%0d count", p), int'(count), 8);
            chk($sformatf("pass%0d overflow", p), int'(overflow), 0);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("pass%0d head%0d", p, i), int'(rd_data),
                    (i < 7) ? (p * 16 + i + 1) : (8'hA0 + p));
                step(1'b0, 8'h00, 1'b1, 1'b0, "pass drain");
            end
            chk($sformatf("pass%0d empty", p), int'(rd_valid), 0);
        end

        // --- clear collides with a new drop ---
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b0, "ovf fill");
        step(1'b1, 8'h99, 1'b0, 1'b0, "ovf drop");
        chk("ovf set", int'(overflow), 1);
        step(1'b1, 8'h9A, 1'b0, 1'b1, "ovf clr+drop");
        chk("ovf clr+drop holds", int'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "ovf clr");
        chk("ovf cleared", int'(overflow), 0);
        chk("ovf head intact", int'(rd_data), 8'h30);

        // --- asynchronous reset mid-burst ---
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, "burst");
        chk("burst count5", int'(count), 5);
        out_we = 1'b1; out_data = 8'h45;
        #3;
        out_we = 1'b0;
        reset  = 1'b1;
        #1;
        chk("async rd_valid", int'(rd_valid), 0);
        chk("async count", int'(count), 0);
        chk("async overflow", int'(overflow), 0);
        chk("async rd_data", int'(rd_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        step(1'b1, 8'h5A, 1'b0, 1'b0, "post reset push");
        chk("post reset data", int'(rd_data), 8'h5A);
        chk("post reset count", int'(count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0, "post reset pop");
        chk("post reset alone", int'(rd_valid), 0);

        // --- duplicate sequence ---
        do_reset();
        step(1'b1, 8'h07, 1'b0, 1'b0, "dup w0");
        step(1'b1, 8'h07, 1'b0, 1'b0, "dup w1");
        step(1'b1, 8'h08, 1'b0, 1'b0, "dup w2");
        step(1'b1, 8'h07, 1'b0, 1'b0, "dup w3");
`ifdef OUT_PORT_DEDUP_EN
        exp_cnt = 3;
        exp_rd  = '{8'h07, 8'h08, 8'h07};
`else
        exp_cnt = 4;
        exp_rd  = '{8'h07, 8'h07, 8'h08, 8'h07};
`endif
        chk("dup count", int'(count), exp_cnt);
        foreach (exp_rd[i]) begin
            chk($sformatf("dup read%0d", i), int'(rd_data), int'(exp_rd[i]));
            step(1'b0, 8'h00, 1'b1, 1'b0, "dup drain");
        end
        chk("dup empty", int'(rd_valid), 0);

        // --- random traffic against the reference model ---
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 DW'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                 "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
